player_shot_controller: RTL and testbench



---
 rtl/player_shot_controller.sv | 100 ++++++++++
 tb/tb_player_shot_controller.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/player_shot_controller.sv
// player_shot_controller: single player laser shot launch, flight, explosion, drawing and hit counting
module player_shot_controller #(
  parameter int SHOT_WIDTH = 2,
  parameter int SHOT_HEIGHT = 8,
  parameter int PLAYER_WIDTH = 24,
  parameter int SHOT_Y_START = 440,
  parameter int Y_TOP = 8,
  parameter int SHOT_VELOCITY = 2,
  parameter int MOVE_INTERVAL = 200000,
  parameter int EXPLODE_CYCLES = 3000000,
  parameter logic [11:0] SHOT_RGB = 12'hFFF,
  parameter logic [11:0] EXPLODE_RGB = 12'hFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        fire_btn,
  input  logic [10:0] player_x,
  input  logic        game_over,
  input  logic        shot_hit,
  input  logic [10:0] pixel_x,
  input  logic [10:0] pixel_y,
  output logic        shot_active,
  output logic [10:0] shot_x,
  output logic [10:0] shot_y,
  output logic        shot_on,
  output logic [11:0] shot_rgb,
  output logic [7:0]  hit_count
);
  localparam int MW = $clog2(MOVE_INTERVAL + 1);
  localparam int EW = $clog2(EXPLODE_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, FLY, EXPLODE} state_t;
  state_t state, state_d;
  logic [1:0] fire_sync;
  logic fire_prev;
  logic [2:0] live;
  logic fire_edge, tick, hit, in_x, in_y, draw;
  logic [MW-1:0] move_cnt, move_d;
  logic [EW-1:0] exp_cnt, exp_d;
  logic [10:0] x_d, y_d;
  logic [7:0] hits_d;
  assign fire_edge = fire_sync[1] & ~fire_prev & live[2];
  assign tick = move_cnt == MW'(MOVE_INTERVAL);
  assign hit = state == FLY && shot_hit;
  assign in_x = {1'b0, pixel_x} >= {1'b0, shot_x} && {1'b0, pixel_x} < {1'b0, shot_x} + 12'(SHOT_WIDTH);
  assign in_y = {1'b0, pixel_y} >= {1'b0, shot_y} && {1'b0, pixel_y} < {1'b0, shot_y} + 12'(SHOT_HEIGHT);
  assign draw = state != IDLE && in_x && in_y;
  assign shot_active = state == FLY;
  always_comb begin
    state_d = state;
    x_d = shot_x;
    y_d = shot_y;
    move_d = move_cnt;
    exp_d = exp_cnt;
    hits_d = hit && hit_count != 8'hFF ? hit_count + 8'd1 : hit_count;
    if (game_over) state_d = IDLE;
    else if (state == IDLE && fire_edge) begin
      state_d = FLY;
      x_d = player_x + 11'(PLAYER_WIDTH / 2 - SHOT_WIDTH / 2);
      y_d = 11'(SHOT_Y_START);
      move_d = '0;
    end else if (hit) begin
      state_d = EXPLODE;
      exp_d = '0;
    end else if (state == FLY) begin
      move_d = tick ? '0 : move_cnt + MW'(1);
      if (tick && shot_y < 11'(Y_TOP + SHOT_VELOCITY)) state_d = IDLE;
      else if (tick) y_d = shot_y - 11'(SHOT_VELOCITY);
    end else if (state == EXPLODE) begin
      exp_d = exp_cnt + EW'(1);
      state_d = exp_cnt == EW'(EXPLODE_CYCLES - 1) ? IDLE : state;
    end
  end
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      fire_sync <= '0;
      fire_prev <= 1'b0;
      live <= '0;
      move_cnt <= '0;
      exp_cnt <= '0;
      shot_x <= '0;
      shot_y <= 11'(SHOT_Y_START);
      hit_count <= '0;
      shot_on <= 1'b0;
      shot_rgb <= '0;
    end else begin
      state <= state_d;
      fire_sync <= {fire_sync[0], fire_btn};
      fire_prev <= fire_sync[1];
      live <= {live[1:0], 1'b1};
      move_cnt <= move_d;
      exp_cnt <= exp_d;
      shot_x <= x_d;
      shot_y <= y_d;
      hit_count <= hits_d;
      shot_on <= draw;
      shot_rgb <= draw ? (state == FLY ? SHOT_RGB : EXPLODE_RGB) : 12'h000;
    end
  end
endmodule

// File: tb/tb_player_shot_controller.sv
// tb_player_shot_controller: randomized scoreboard bench against a behavioural shot model
module tb_player_shot_controller;
  localparam int MI = 4;
  localparam int EC = 10;
  typedef struct packed {
    logic act;
    logic [10:0] x;
    logic [10:0] y;
    logic on;
    logic [11:0] rgb;
    logic [7:0] hc;
  } exp_t;
  logic clk = 0, reset = 1, fire_btn = 0, game_over = 0, shot_hit = 0;
  logic [10:0] player_x = 11'd100, pixel_x = 0, pixel_y = 0;
  logic shot_active, shot_on;
  logic [10:0] shot_x, shot_y;
  logic [11:0] shot_rgb;
  logic [7:0] hit_count;
  exp_t q[$];
  bit bh[$];
  int checks = 0, errors = 0;
  int mode = 0, mx = 0, my = 440, mh = 0, t0 = 0, te = 0, n = 0;
  int p_tog = 0, p_hit = 0, p_go = 0, p_px = 0;
  always #5 clk = ~clk;
  player_shot_controller #(.MOVE_INTERVAL(MI), .EXPLODE_CYCLES(EC)) dut (
    .clk(clk), .reset(reset), .fire_btn(fire_btn), .player_x(player_x),
    .game_over(game_over), .shot_hit(shot_hit), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .shot_active(shot_active), .shot_x(shot_x), .shot_y(shot_y), .shot_on(shot_on),
    .shot_rgb(shot_rgb), .hit_count(hit_count)
  );
  task automatic chk(input string nm, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", nm, act, req);
    end
  endtask
  task automatic check_reset(input string tag);
    chk({tag, "_active"}, int'(shot_active), 0);
    chk({tag, "_x"}, int'(shot_x), 0);
    chk({tag, "_y"}, int'(shot_y), 440);
    chk({tag, "_on"}, int'(shot_on), 0);
    chk({tag, "_rgb"}, int'(shot_rgb), 0);
    chk({tag, "_hits"}, int'(hit_count), 0);
  endtask
  task automatic model_reset();
    mode = 0; mx = 0; my = 440; mh = 0; n = 0;
    bh.delete();
    q.delete();
  endtask
  task automatic predict();
    exp_t e;
    bit fe, on;
    on = mode != 0 && pixel_x >= mx && pixel_x < mx + 2 && pixel_y >= my && pixel_y < my + 8;
    e.on = on;
    e.rgb = !on ? 12'h000 : mode == 1 ? 12'hFFF : 12'hFF0;
    bh.push_back(fire_btn);
    fe = n >= 3 && bh[n-2] && !bh[n-3];
    if (mode == 1 && shot_hit && mh < 255) mh++;
    if (mode == 0) begin
      if (fe && !game_over) begin
        mode = 1; mx = (int'(player_x) + 11) % 2048; my = 440; t0 = n;
      end
    end else if (game_over) mode = 0;
    else if (mode == 1) begin
      if (shot_hit) begin
        mode = 2; te = n;
      end else if ((n - t0) % (MI + 1) == 0) begin
        if (my < 10) mode = 0;
        else my -= 2;
      end
    end else if (n - te == EC) mode = 0;
    e.act = mode == 1;
    e.x = 11'(mx);
    e.y = 11'(my);
    e.hc = 8'(mh);
    q.push_back(e);
    n++;
  endtask
  task automatic drive();
    if ($urandom_range(999) < p_tog) fire_btn = ~fire_btn;
    shot_hit = $urandom_range(999) < p_hit;
    game_over = $urandom_range(999) < p_go;
    player_x = $urandom_range(999) < p_px ? 11'd2040 : 11'd100;
    if ($urandom_range(1) == 1) begin
      pixel_x = 11'(mx + int'($urandom_range(3)) - 1);
      pixel_y = 11'(my + int'($urandom_range(9)) - 1);
    end else begin
      pixel_x = 11'($urandom_range(2047));
      pixel_y = 11'($urandom_range(2047));
    end
    predict();
  endtask
  task automatic step();
    @(posedge clk);
    #2;
    drive();
  endtask
  initial forever begin
    exp_t e, a;
    @(posedge clk);
    #1;
    if (reset && q.size() > 0) begin
      e = q.pop_front();
      a = '{shot_active, shot_x, shot_y, shot_on, shot_rgb, hit_count};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle t=%0t actual act=%0b x=%0d y=%0d on=%0b rgb=%h hits=%0d required act=%0b x=%0d y=%0d on=%0b rgb=%h hits=%0d",
                 $time, a.act, a.x, a.y, a.on, a.rgb, a.hc, e.act, e.x, e.y, e.on, e.rgb, e.hc);
      end
    end
  end
  initial begin
    #1 reset = 0;
    #21;
    check_reset("reset");
    reset = 1;
    model_reset();
    p_tog = 50;
    drive();
    repeat (40) step();
    repeat (1500) step();
    p_tog = 100; p_hit = 30; p_go = 5;
    repeat (3000) step();
    p_tog = 300; p_hit = 300; p_go = 0; p_px = 100;
    for (int i = 0; i < 20000 && mh < 255; i++) step();
    repeat (400) step();
    chk("hit_saturation", int'(hit_count), 255);
    p_px = 0;
    for (int i = 0; i < 2000 && mode != 2; i++) step();
    chk("reach_explode", mode, 2);
    @(posedge clk);
    #3;
    fire_btn = 1;
    reset = 0;
    #1;
    check_reset("mid_explode_reset");
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #2;
    reset = 1;
    p_tog = 0; p_hit = 0; p_go = 0;
    drive();
    repeat (30) step();
    chk("held_button_no_launch", int'(shot_active), 0);
    p_tog = 100; p_hit = 20;
    repeat (300) step();
    @(posedge clk);
    #3;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
